// File: rtl/ysyx_23060332_wbu_pkg.sv
// rtl/ysyx_23060332_wbu_pkg.sv - shared widths and load funct3 codes for the write-back unit
package ysyx_23060332_wbu_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  localparam int RegAddrBus = AW;
  localparam int RegDataBus = XLEN;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060332_ldext.sv
// rtl/ysyx_23060332_ldext.sv - load data alignment and sign/zero extension
module ysyx_23060332_ldext
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [RegDataBus-1:0] rdata,
  output logic [RegDataBus-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then extend according to the load type
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{(RegDataBus-8){byte_sel[7]}}, byte_sel};
      LBU:     data = {{(RegDataBus-8){1'b0}}, byte_sel};
      LH:      data = {{(RegDataBus-16){half_sel[15]}}, half_sel};
      LHU:     data = {{(RegDataBus-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// rtl/ysyx_23060332_wbu.sv - write-back unit: arbitration, pending-write scoreboard, regfile write port
module ysyx_23060332_wbu
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [RegAddrBus-1:0] iss_rd,
  input  logic                  iss_wen,
  input  logic [RegAddrBus-1:0] chk_r1,
  input  logic [RegAddrBus-1:0] chk_r2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [RegAddrBus-1:0] ex_rd,
  input  logic                  ex_wen,
  input  logic [RegDataBus-1:0] ex_data,
  input  logic [RegDataBus-1:0] ex_pc,
  input  logic                  ls_valid,
  output logic                  ls_ready,
  input  logic [RegAddrBus-1:0] ls_rd,
  input  logic [RegDataBus-1:0] ls_rdata,
  input  logic [1:0]            ls_addr_lo,
  input  logic [2:0]            ls_funct3,
  input  logic [RegDataBus-1:0] ls_pc,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegDataBus-1:0] wdata,
  output logic                  reg_wen,
  output logic                  commit_valid,
  output logic [RegDataBus-1:0] commit_pc
);

  logic [RegDataBus-1:0] ld_data;
  logic                  acc;
  logic [RegAddrBus-1:0] acc_rd;
  logic                  acc_wen;
  logic [RegDataBus-1:0] acc_data;
  logic [RegDataBus-1:0] acc_pc;
  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       set_mask;
  logic [NREG-1:0]       clr_mask;

  ysyx_23060332_ldext u_ldext (
    .funct3  (ls_funct3),
    .addr_lo (ls_addr_lo),
    .rdata   (ls_rdata),
    .data    (ld_data)
  );

  // LSU always wins; the EXU is only accepted when no load response is present
  always_comb begin
    ls_ready = 1'b1;
    ex_ready = !ls_valid;
    acc      = ls_valid || ex_valid;
    acc_rd   = ls_valid ? ls_rd    : ex_rd;
    acc_wen  = ls_valid ? 1'b1     : ex_wen;
    acc_data = ls_valid ? ld_data  : ex_data;
    acc_pc   = ls_valid ? ls_pc    : ex_pc;
  end

  // Scoreboard update masks; a same-cycle issue re-sets a bit the acceptance clears
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && iss_wen && (iss_rd != '0)) set_mask = NREG'(1) << iss_rd;
    if (acc && acc_wen) clr_mask = NREG'(1) << acc_rd;
  end

  // Pending-write mask; x0 never tracked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= ((pending & ~clr_mask) | set_mask) & ~NREG'(1);
  end

  // Output registers loaded on acceptance; enables self-clear one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr        <= '0;
      wdata        <= '0;
      reg_wen      <= 1'b0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
    end else if (acc) begin
      waddr        <= acc_rd;
      wdata        <= acc_data;
      reg_wen      <= acc_wen && (acc_rd != '0);
      commit_valid <= 1'b1;
      commit_pc    <= acc_pc;
    end else begin
      reg_wen      <= 1'b0;
      commit_valid <= 1'b0;
    end
  end

  // Busy also covers the cycle where the register file has not yet captured wdata
  always_comb begin
    busy1 = (chk_r1 != '0) && (pending[chk_r1] || (reg_wen && (waddr == chk_r1)));
    busy2 = (chk_r2 != '0) && (pending[chk_r2] || (reg_wen && (waddr == chk_r2)));
  end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// tb/tb_ysyx_23060332_wbu.sv - randomized scoreboard bench for the write-back unit
module tb_ysyx_23060332_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iss_valid = 1'b0, iss_wen = 1'b0;
  logic [4:0]  iss_rd = '0, chk_r1 = '0, chk_r2 = '0;
  logic        busy1, busy2;
  logic        ex_valid = 1'b0, ex_wen = 1'b0, ex_ready;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_data = '0, ex_pc = '0;
  logic        ls_valid = 1'b0, ls_ready;
  logic [4:0]  ls_rd = '0;
  logic [31:0] ls_rdata = '0, ls_pc = '0;
  logic [1:0]  ls_addr_lo = '0;
  logic [2:0]  ls_funct3 = '0;
  logic [4:0]  waddr;
  logic [31:0] wdata, commit_pc;
  logic        reg_wen, commit_valid;

  always #5 clk = ~clk;

  ysyx_23060332_wbu dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wen(iss_wen),
    .chk_r1(chk_r1), .chk_r2(chk_r2), .busy1(busy1), .busy2(busy2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_data(ex_data), .ex_pc(ex_pc),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_rd(ls_rd), .ls_rdata(ls_rdata),
    .ls_addr_lo(ls_addr_lo), .ls_funct3(ls_funct3), .ls_pc(ls_pc),
    .waddr(waddr), .wdata(wdata), .reg_wen(reg_wen),
    .commit_valid(commit_valid), .commit_pc(commit_pc)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic        pend[32];
  logic [4:0]  last_wr;
  int          errors = 0;
  int          checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(logic [2:0] f3, logic [1:0] lo, logic [31:0] rdata);
    int unsigned b, h;
    b = (rdata >> (8 * lo)) & 32'hFF;
    h = (rdata >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic busy_model(logic [4:0] r);
    return (r != 0) && (pend[r] || (last_wr == r));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    last_wr = '0;
  endtask

  // One cycle: predict acceptance from driven inputs, check mid-cycle, advance the model at the edge
  task automatic step();
    exp_t e;
    logic acc, awen;
    acc  = 1'b0;
    awen = 1'b0;
    e.rd = '0; e.data = '0; e.wen = 1'b0; e.pc = '0;
    if (ls_valid) begin
      acc = 1'b1; awen = 1'b1;
      e.rd = ls_rd; e.data = ld_model(ls_funct3, ls_addr_lo, ls_rdata); e.pc = ls_pc;
    end else if (ex_valid) begin
      acc = 1'b1; awen = ex_wen;
      e.rd = ex_rd; e.data = ex_data; e.pc = ex_pc;
    end
    e.wen = awen && (e.rd != 0);
    if (acc) q.push_back(e);
    @(negedge clk);
    check("busy1", busy1, busy_model(chk_r1));
    check("busy2", busy2, busy_model(chk_r2));
    check("ex_ready", ex_ready, !ls_valid);
    check("ls_ready", ls_ready, 1);
    @(posedge clk);
    last_wr = (acc && e.wen) ? e.rd : 5'd0;
    if (acc && awen) pend[e.rd] = 1'b0;
    if (iss_valid && iss_wen && iss_rd != 0) pend[iss_rd] = 1'b1;
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ls_valid = 1'b0; iss_valid = 1'b0;
  endtask

  // Monitor: every retire pulse must match the oldest predicted write
  always @(negedge clk) begin
    if (rst) begin
      if (commit_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_commit: got commit with pc %h, expected none", commit_pc);
        end else begin
          mon_e = q.pop_front();
          check("waddr", waddr, mon_e.rd);
          check("reg_wen", reg_wen, mon_e.wen);
          check("commit_pc", commit_pc, mon_e.pc);
          if (mon_e.wen) check("wdata", wdata, mon_e.data);
        end
      end else begin
        check("idle_reg_wen", reg_wen, 0);
      end
    end
  end

  logic [31:0] lvec_rd [4] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
  logic [2:0]  lvec_f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  lvec_lo [4] = '{2'd2, 2'd3, 2'd2, 2'd0};
  logic [31:0] lvec_ex [4] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};

  initial begin
    logic hold;
    model_reset();
    #1;
    check("rst_reg_wen", reg_wen, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_commit_pc", commit_pc, 0);
    check("rst_ls_ready", ls_ready, 1);
    check("rst_ex_ready", ex_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Basic EXU write
    ex_valid = 1; ex_rd = 5; ex_wen = 1; ex_data = 32'h1234_5678; ex_pc = 32'h8000_0000;
    step();
    check("ex_wen_n1", reg_wen, 1);
    check("ex_waddr_n1", waddr, 5);
    check("ex_wdata_n1", wdata, 32'h1234_5678);
    idle();
    step();
    check("ex_wen_n2", reg_wen, 0);

    // Simultaneous EXU and LSU: load first, EXU held and written next
    ex_valid = 1; ex_rd = 3; ex_wen = 1; ex_data = 32'hAAAA_0003; ex_pc = 32'h8000_0010;
    ls_valid = 1; ls_rd = 4; ls_funct3 = 3'b010; ls_addr_lo = 0; ls_rdata = 32'hBBBB_0004; ls_pc = 32'h8000_000C;
    step();
    check("prio_first", waddr, 4);
    ls_valid = 0;
    step();
    check("prio_second", waddr, 3);
    check("prio_second_data", wdata, 32'hAAAA_0003);
    idle();
    step();

    // Load alignment vectors
    for (int i = 0; i < 4; i++) begin
      ls_valid = 1; ls_rd = 6; ls_rdata = lvec_rd[i]; ls_funct3 = lvec_f3[i];
      ls_addr_lo = lvec_lo[i]; ls_pc = 32'h8000_0100 + 4 * i;
      step();
      check("load_vec", wdata, lvec_ex[i]);
    end
    idle();
    step();

    // rd = 0 retires without writing
    ex_valid = 1; ex_rd = 0; ex_wen = 1; ex_data = 32'hDEAD_BEEF; ex_pc = 32'h8000_0200;
    step();
    check("x0_reg_wen", reg_wen, 0);
    check("x0_commit", commit_valid, 1);
    idle();
    step();

    // Scoreboard on x7
    chk_r1 = 7; chk_r2 = 0;
    iss_valid = 1; iss_rd = 7; iss_wen = 1;
    step();
    iss_valid = 0;
    check("sb_busy_issue", busy1, 1);
    step();
    ex_valid = 1; ex_rd = 7; ex_wen = 1; ex_data = 32'h7777; ex_pc = 32'h8000_0300;
    step();
    idle();
    check("sb_busy_wen", busy1, 1);
    step();
    check("sb_busy_drop", busy1, 0);
    iss_valid = 1; iss_rd = 7; iss_wen = 1;
    step();
    iss_valid = 1; ex_valid = 1; ex_rd = 7; ex_wen = 1; ex_data = 32'h7778; ex_pc = 32'h8000_0304;
    step();
    idle();
    step();
    check("sb_reissue_busy", busy1, 1);
    ex_valid = 1; ex_rd = 7; ex_wen = 1; ex_data = 32'h7779; ex_pc = 32'h8000_0308;
    step();
    idle();
    step();
    step();

    // Randomized traffic with EXU hold-while-rejected
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      iss_valid = $urandom_range(0, 1);
      iss_rd    = 5'($urandom_range(0, 7));
      iss_wen   = $urandom_range(0, 3) != 0;
      chk_r1    = 5'($urandom_range(0, 7));
      chk_r2    = 5'($urandom_range(0, 7));
      if (!hold) begin
        ex_valid = $urandom_range(0, 1);
        ex_wen   = $urandom_range(0, 3) != 0;
        ex_rd    = ex_wen ? 5'($urandom_range(0, 7)) : 5'd0;
        ex_data  = $urandom;
        ex_pc    = $urandom & 32'hFFFF_FFFC;
      end
      ls_valid   = $urandom_range(0, 2) == 0;
      ls_rd      = 5'($urandom_range(0, 7));
      ls_rdata   = $urandom;
      ls_addr_lo = 2'($urandom_range(0, 3));
      ls_funct3  = 3'($urandom_range(0, 7));
      ls_pc      = $urandom & 32'hFFFF_FFFC;
      hold = ex_valid && ls_valid;
      step();
    end
    idle();
    step();
    step();

    // Asynchronous reset during an in-flight write
    chk_r1 = 9; chk_r2 = 10;
    iss_valid = 1; iss_rd = 9; iss_wen = 1;
    step();
    iss_rd = 10;
    step();
    iss_valid = 0; ex_valid = 1; ex_rd = 9; ex_wen = 1; ex_data = 32'h9999; ex_pc = 32'h8000_0400;
    step();
    idle();
    rst = 1'b0;
    #1;
    check("arst_reg_wen", reg_wen, 0);
    check("arst_commit", commit_valid, 0);
    check("arst_busy1", busy1, 0);
    check("arst_busy2", busy2, 0);
    q.delete();
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy2", busy2, 0);
    step();
    step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding writes, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
